alsu_op_sequencer: RTL and testbench
====================================

// Module: alsu_op_sequencer
// PURPOSE
//  Shares one ALSU instance between NUM_REQ requesters. Each requester submits one packed command over a
//  valid/ready handshake. A round-robin arbiter grants one requester at a time, with one command outstanding.
//  The block drives the ALSU control/data inputs, preloads the ALSU output for shift/rotate commands, and
//  holds shift/rotate commands for REPEAT+1 cycles. It then captures out/leds after the ALSU latency and
//  returns a tagged response. Sits between the requester fabric and the ALSU in the top-level datapath.
// PARAMETERS
//  NUM_REQ       2   number of requesters (2..8)
//  ALSU_LATENCY  2   clock edges from ALSU input sample to updated out/leds (input reg + output reg)
// PORTS
//  clk           in   1        clock; the ALSU uses the same clock
//  reset_n       in   1        asynchronous active-low reset; the top level inverts it for the ALSU active-high reset
//  req_valid     in   NUM_REQ  command valid per requester
//  req_cmd       in   NUM_REQ*19 per requester alsu_cmd_t {opcode3,A3,B3,cin,serial_in,red_op_A,red_op_B,bypass_A,bypass_B,direction,repeat3}
//  req_ready     out  NUM_REQ  one-hot accept pulse; command accepted when valid&ready
//  rsp_valid     out  1        response valid; held until rsp_ready
//  rsp_ready     in   1        response consumer ready
//  rsp_id        out  $clog2(NUM_REQ) index of the requester that issued the command
//  rsp_out       out  6        captured ALSU out
//  rsp_leds      out  16       captured ALSU leds
//  rsp_err       out  1        command was invalid (opcode 11x, or red_op_* with opcode >= 3'b010)
//  alsu_opcode, alsu_A, alsu_B  out 3 each; alsu_cin, alsu_serial_in, alsu_red_op_A/B, alsu_bypass_A/B,
//                alsu_direction out 1 each   registered ALSU inputs
//  alsu_out      in   6        ALSU result
//  alsu_leds     in   16       ALSU leds
// BEHAVIOUR
//  Reset: FSM=IDLE; rr pointer=0; req_ready=0; rsp_valid=0; rsp_id/out/leds/err=0. All alsu_* outputs drive
//    the IDLE command: all fields 0 (opcode 000, no bypass, no red_op). In this state ALSU out goes to 0 and leds hold.
//  FSM: IDLE -> [PRELOAD] -> EXEC -> DRAIN -> RESP -> IDLE.
//   IDLE: if any req_valid, grant the first requester at or after the rr pointer. Pulse its req_ready for this one
//     cycle and latch the command. Set rr pointer = grant+1 (mod NUM_REQ). Go to PRELOAD if opcode is 100/101,
//     else to EXEC.
//   PRELOAD (1 cycle): drive opcode 000, bypass_A=1, A=cmd.A. This loads ALSU out = {3'b0,A}.
//   EXEC: drive the latched command for repeat+1 cycles for opcode 100/101, and for exactly 1 cycle otherwise
//     (repeat is ignored). A 3-bit down-counter controls the hold.
//   DRAIN: drive the IDLE command for ALSU_LATENCY cycles. On the last DRAIN cycle, sample alsu_out/alsu_leds
//     into rsp_*, set rsp_err from the decoded command, set rsp_id, and assert rsp_valid next cycle.
//   RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE.
//  Timing: the last EXEC cycle is L; the result is sampled in cycle L+ALSU_LATENCY; rsp_valid is first high in L+3.
//  No new grant while the FSM is not IDLE; req_ready=0 outside IDLE.
//  Invalid commands are still issued. The ALSU toggles leds once per held cycle; rsp_err=1 and the captured values are returned.
//  Simultaneous valids resolve by round-robin. A requester that deasserts valid before grant is simply not granted.
//  Reset mid-operation aborts the operation. No response is produced; the ALSU is reset by the same event.
// STRUCTURE
//  alsu_pkg: alsu_cmd_t packed struct, opcode enum (OR,XOR,ADD,MUL,SHIFT,ROTATE,INV6,INV7), ALSU_LATENCY,
//    IDLE_CMD constant, function is_invalid(alsu_cmd_t).
//  Sub-module rr_arbiter (NUM_REQ): req vector, pointer advance enable -> one-hot grant + index.
// TESTING
//  1. Single req0: OR, A=3'b101, B=3'b010 -> rsp_out=6'h07, rsp_err=0, rsp_id=0, rsp_valid 4 cycles after accept.
//  2. Both valid in the same cycle, held for 4 commands -> grants alternate 0,1,0,1; rsp_id follows the grants.
//  3. SHIFT dir=1, serial_in=1, A=3'b101, repeat=1 -> preload 000101, then 001011, then 010111; rsp_out=6'h17.
//  4. ROTATE dir=0, A=3'b001, repeat=0 -> rsp_out=6'b100000.
//  5. ADD with red_op_A=1 -> rsp_err=1, rsp_out=0, rsp_leds=16'hFFFF from reset.
//     Hold rsp_ready=0 for 5 cycles -> rsp_* stable and no new grant.
//  6. Assert reset_n=0 during EXEC -> all outputs at reset values next cycle and no response.
//     After release, a new request is accepted.

Source files
------------

// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - ALSU command types, constants and command validity decode
// Purpose: shared definitions for the ALSU operation sequencer.
//   alsu_cmd_t   packed 19-bit requester command
//   IDLE_CMD     command driven when the ALSU is not in use (plain OR of zeros)
//   is_invalid   opcode 11x, or a reduction flag on an opcode that has no reduction form
//   is_shift_op  SHIFT/ROTATE, which need a preload and a multi-cycle hold
package alsu_pkg;

    localparam int ALSU_LATENCY = 2;
    localparam int CMD_W        = 19;

    typedef enum logic [2:0] {
        OP_OR     = 3'b000,
        OP_XOR    = 3'b001,
        OP_ADD    = 3'b010,
        OP_MUL    = 3'b011,
        OP_SHIFT  = 3'b100,
        OP_ROTATE = 3'b101,
        OP_INV6   = 3'b110,
        OP_INV7   = 3'b111
    } alsu_opcode_e;

    // Field order matches the requester wire format, opcode in the MSBs.
    typedef struct packed {
        alsu_opcode_e opcode;
        logic [2:0]   a;
        logic [2:0]   b;
        logic         cin;
        logic         serial_in;
        logic         red_op_a;
        logic         red_op_b;
        logic         bypass_a;
        logic         bypass_b;
        logic         direction;
        logic [2:0]   rpt;
    } alsu_cmd_t;

    localparam alsu_cmd_t IDLE_CMD = '0;

    function automatic logic is_invalid(input alsu_cmd_t cmd);
        logic bad_op;
        logic bad_red;
        bad_op  = (cmd.opcode == OP_INV6) || (cmd.opcode == OP_INV7);
        bad_red = (cmd.red_op_a || cmd.red_op_b) && (cmd.opcode >= OP_ADD);
        return bad_op || bad_red;
    endfunction

    function automatic logic is_shift_op(input alsu_opcode_e op);
        return (op == OP_SHIFT) || (op == OP_ROTATE);
    endfunction

endpackage

// File: rtl/alsu_op_sequencer_rr_arbiter.sv
// rtl/alsu_op_sequencer_rr_arbiter.sv - round-robin arbiter with pointer advance on grant
// Purpose: picks the first requester at or after the round-robin pointer.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_req             request vector
//   i_advance         when high and a grant exists, pointer moves to grant+1 (mod NUM_REQ)
//   o_grant           one-hot grant (combinational)
//   o_grant_idx       index of the granted requester
//   o_grant_any       at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    logic [IDX_W-1:0] r_ptr;

    // Two descending scans: the first leaves the lowest requester overall, the
    // second overrides it with the lowest requester at or above the pointer.
    // The result is the first requester at or after the pointer, wrapping.
    always_comb begin
        o_grant_any = 1'b0;
        o_grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant_any = 1'b1;
                o_grant_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i] && (IDX_W'(i) >= r_ptr)) begin
                o_grant_idx = IDX_W'(i);
            end
        end
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_grant_any && (o_grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_grant_any) begin
            r_ptr <= (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alsu_op_sequencer.sv
// rtl/alsu_op_sequencer.sv - shares one ALSU between NUM_REQ requesters, one command outstanding
// Purpose: arbitrates requester commands, sequences them onto the ALSU inputs
//   (preload + held execution for SHIFT/ROTATE), captures out/leds after the ALSU
//   latency and returns a tagged response.
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_req_valid / i_req_cmd       per-requester command handshake (19 bits per requester)
//   o_req_ready                   one-hot accept, only in IDLE
//   o_rsp_valid / i_rsp_ready     response handshake
//   o_rsp_id/out/leds/err         response payload
//   o_alsu_*                      registered ALSU control/data inputs
//   i_alsu_out / i_alsu_leds      ALSU results
module alsu_op_sequencer #(
    parameter int NUM_REQ      = 2,
    parameter int ALSU_LATENCY = alsu_pkg::ALSU_LATENCY
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic [NUM_REQ-1:0]                  i_req_valid,
    input  logic [NUM_REQ*alsu_pkg::CMD_W-1:0]  i_req_cmd,
    output logic [NUM_REQ-1:0]                  o_req_ready,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]          o_rsp_id,
    output logic [5:0]                          o_rsp_out,
    output logic [15:0]                         o_rsp_leds,
    output logic                                o_rsp_err,
    output logic [2:0]                          o_alsu_opcode,
    output logic [2:0]                          o_alsu_a,
    output logic [2:0]                          o_alsu_b,
    output logic                                o_alsu_cin,
    output logic                                o_alsu_serial_in,
    output logic                                o_alsu_red_op_a,
    output logic                                o_alsu_red_op_b,
    output logic                                o_alsu_bypass_a,
    output logic                                o_alsu_bypass_b,
    output logic                                o_alsu_direction,
    input  logic [5:0]                          i_alsu_out,
    input  logic [15:0]                         i_alsu_leds
);

    import alsu_pkg::*;

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int DRAIN_W = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]         r_state;
    alsu_cmd_t          r_cmd;
    alsu_cmd_t          r_alsu;
    logic [2:0]         r_hold_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [ID_W-1:0]    r_id;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [5:0]         r_rsp_out;
    logic [15:0]        r_rsp_leds;
    logic               r_rsp_err;

    alsu_cmd_t          w_cmds [NUM_REQ];
    alsu_cmd_t          w_sel_cmd;
    alsu_cmd_t          w_preload_cmd;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic               w_idle;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_cmds[g] = alsu_cmd_t'(i_req_cmd[g*CMD_W +: CMD_W]);
    end

    assign w_idle = (r_state == S_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req       (i_req_valid),
        .i_advance   (w_idle),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign w_sel_cmd   = w_cmds[w_grant_idx];
    assign o_req_ready = w_grant & {NUM_REQ{w_idle}};

    // Preload: bypass A through a plain OR so the ALSU output register holds {3'b0,A}
    // before the first shift/rotate step operates on it.
    always_comb begin
        w_preload_cmd          = IDLE_CMD;
        w_preload_cmd.bypass_a = 1'b1;
        w_preload_cmd.a        = w_sel_cmd.a;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= IDLE_CMD;
            r_alsu      <= IDLE_CMD;
            r_hold_cnt  <= '0;
            r_drain_cnt <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_out   <= '0;
            r_rsp_leds  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_cmd <= w_sel_cmd;
                        r_id  <= w_grant_idx;
                        if (is_shift_op(w_sel_cmd.opcode)) begin
                            r_state <= S_PRELOAD;
                            r_alsu  <= w_preload_cmd;
                        end else begin
                            // Non-shift commands ignore the repeat field: one cycle only.
                            r_state    <= S_EXEC;
                            r_alsu     <= w_sel_cmd;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                S_PRELOAD: begin
                    r_state    <= S_EXEC;
                    r_alsu     <= r_cmd;
                    r_hold_cnt <= r_cmd.rpt;
                end
                S_EXEC: begin
                    if (r_hold_cnt == 3'd0) begin
                        r_state     <= S_DRAIN;
                        r_alsu      <= IDLE_CMD;
                        r_drain_cnt <= DRAIN_W'(ALSU_LATENCY - 1);
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 3'd1;
                    end
                end
                S_DRAIN: begin
                    // The last DRAIN cycle is the first one in which the ALSU
                    // output reflects the final EXEC cycle.
                    if (r_drain_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_out   <= i_alsu_out;
                        r_rsp_leds  <= i_alsu_leds;
                        r_rsp_err   <= is_invalid(r_cmd);
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_alsu  <= IDLE_CMD;
                end
            endcase
        end
    end

    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_id         = r_rsp_id;
    assign o_rsp_out        = r_rsp_out;
    assign o_rsp_leds       = r_rsp_leds;
    assign o_rsp_err        = r_rsp_err;

    assign o_alsu_opcode    = r_alsu.opcode;
    assign o_alsu_a         = r_alsu.a;
    assign o_alsu_b         = r_alsu.b;
    assign o_alsu_cin       = r_alsu.cin;
    assign o_alsu_serial_in = r_alsu.serial_in;
    assign o_alsu_red_op_a  = r_alsu.red_op_a;
    assign o_alsu_red_op_b  = r_alsu.red_op_b;
    assign o_alsu_bypass_a  = r_alsu.bypass_a;
    assign o_alsu_bypass_b  = r_alsu.bypass_b;
    assign o_alsu_direction = r_alsu.direction;

endmodule

// File: tb/tb_alsu_op_sequencer.sv
// tb/tb_alsu_op_sequencer.sv - directed and randomized self-checking bench for alsu_op_sequencer
module tb_alsu_op_sequencer;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
        logic       direction;
        logic [2:0] rpt;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [37:0] req_cmd;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic        rsp_err;
    logic [2:0]  alsu_opcode, alsu_a, alsu_b;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b;
    logic        alsu_bypass_a, alsu_bypass_b, alsu_direction;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_leds;
    int ref_ptr;

    always #5 clk = ~clk;

    alsu_op_sequencer #(.NUM_REQ(2), .ALSU_LATENCY(2)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_req_valid      (req_valid),
        .i_req_cmd        (req_cmd),
        .o_req_ready      (req_ready),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_id         (rsp_id),
        .o_rsp_out        (rsp_out),
        .o_rsp_leds       (rsp_leds),
        .o_rsp_err        (rsp_err),
        .o_alsu_opcode    (alsu_opcode),
        .o_alsu_a         (alsu_a),
        .o_alsu_b         (alsu_b),
        .o_alsu_cin       (alsu_cin),
        .o_alsu_serial_in (alsu_serial_in),
        .o_alsu_red_op_a  (alsu_red_op_a),
        .o_alsu_red_op_b  (alsu_red_op_b),
        .o_alsu_bypass_a  (alsu_bypass_a),
        .o_alsu_bypass_b  (alsu_bypass_b),
        .o_alsu_direction (alsu_direction),
        .i_alsu_out       (alsu_out),
        .i_alsu_leds      (alsu_leds)
    );

    // Behavioural ALSU rules: invalid -> out 0 and leds toggle; otherwise leds hold.
    function automatic logic bad_cmd(input cmd_t c);
        return (c.opcode >= 3'd6) || ((c.red_op_a || c.red_op_b) && (c.opcode >= 3'd2));
    endfunction

    function automatic logic [21:0] alsu_step(input cmd_t c, input logic [5:0] o, input logic [15:0] l);
        logic [5:0] r;
        if (bad_cmd(c)) return {6'd0, ~l};
        if (c.bypass_a) return {3'd0, c.a, l};
        if (c.bypass_b) return {3'd0, c.b, l};
        case (c.opcode)
            3'd0:    r = c.red_op_a ? {5'd0, |c.a} : (c.red_op_b ? {5'd0, |c.b} : {3'd0, c.a | c.b});
            3'd1:    r = c.red_op_a ? {5'd0, ^c.a} : (c.red_op_b ? {5'd0, ^c.b} : {3'd0, c.a ^ c.b});
            3'd2:    r = 6'(c.a) + 6'(c.b) + 6'(c.cin);
            3'd3:    r = 6'(c.a) * 6'(c.b);
            3'd4:    r = c.direction ? {o[4:0], c.serial_in} : {c.serial_in, o[5:1]};
            default: r = c.direction ? {o[4:0], o[5]} : {o[0], o[5:1]};
        endcase
        return {r, l};
    endfunction

    // ALSU instance model: input register then output register, same reset event.
    cmd_t        alsu_in_r;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alsu_in_r <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            alsu_in_r <= {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_red_op_a,
                          alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction, 3'b000};
            {alsu_out, alsu_leds} <= alsu_step(alsu_in_r, alsu_out, alsu_leds);
        end
    end

    // Reference: what one command returns, and its accept-to-response latency.
    task automatic predict(input cmd_t c, output logic [5:0] o, output logic [15:0] l,
                           output logic e, output int lat);
        logic [21:0] s;
        logic [5:0]  acc;
        int          held;
        acc  = 6'd0;
        held = 1;
        lat  = 3;
        if (c.opcode == 3'd4 || c.opcode == 3'd5) begin
            acc  = {3'd0, c.a};
            held = int'(c.rpt) + 1;
            lat  = 3 + held;
        end
        for (int i = 0; i < held; i++) begin
            s        = alsu_step(c, acc, ref_leds);
            acc      = s[21:16];
            ref_leds = s[15:0];
        end
        o = acc;
        l = ref_leds;
        e = bad_cmd(c);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp"}, 32'({req_ready, rsp_valid, rsp_id, rsp_err, rsp_out}), 32'd0);
        chk({tag, "_leds"}, 32'(rsp_leds), 32'd0);
        chk({tag, "_alsu"}, 32'({alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_red_op_a,
                                 alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction}), 32'd0);
    endtask

    task automatic send(input int r, input cmd_t c);
        int n;
        n = 0;
        req_cmd[r*19 +: 19] = c;
        req_valid[r] = 1'b1;
        @(negedge clk);
        while (!req_ready[r] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'(1 << r));
        ref_ptr = (r + 1) % 2;
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int id, input cmd_t c, input int hold);
        logic [5:0]  eo;
        logic [15:0] el;
        logic        ee;
        int          lat;
        int          k;
        k = 0;
        predict(c, eo, el, ee, lat);
        rsp_ready = (hold == 0);
        @(negedge clk);
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_out"}, 32'(rsp_out), 32'(eo));
        chk({tag, "_leds"}, 32'(rsp_leds), 32'(el));
        chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'({rsp_valid, rsp_err, rsp_out, rsp_leds, req_ready}),
                32'({1'b1, ee, eo, el, 2'b00}));
        end
        if (hold > 0) req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c, c0, c1;
        int   seen;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_cmd   = '0;
        rsp_ready = 1'b1;
        ref_leds  = 16'd0;
        ref_ptr   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // OR A=101 B=010 -> 0x07, response 4 cycles after accept
        c = '0; c.opcode = 3'd0; c.a = 3'b101; c.b = 3'b010;
        send(0, c);
        expect_rsp("t1_or", 0, c, 0);

        // SHIFT left, serial_in=1, A=101, repeat=1 -> 0x17
        c = '0; c.opcode = 3'd4; c.direction = 1'b1; c.serial_in = 1'b1; c.a = 3'b101; c.rpt = 3'd1;
        send(0, c);
        expect_rsp("t3_shift", 0, c, 0);

        // ROTATE right, A=001, repeat=0 -> 100000
        c = '0; c.opcode = 3'd5; c.a = 3'b001;
        send(0, c);
        expect_rsp("t4_rot", 0, c, 0);

        // ADD with red_op_A: invalid, leds toggle from reset value; response held 5 cycles
        // while requester 1 asks and must not be granted.
        c = '0; c.opcode = 3'd2; c.red_op_a = 1'b1; c.a = 3'b011; c.b = 3'b110;
        send(0, c);
        req_cmd[37:19] = 19'h12345;
        req_valid[1]   = 1'b1;
        expect_rsp("t5_inv", 0, c, 5);

        // Reset during EXEC of a long shift aborts it without a response.
        c = '0; c.opcode = 3'd4; c.direction = 1'b1; c.a = 3'b011; c.rpt = 3'd7;
        send(0, c);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t6_in_exec", 32'(alsu_opcode), 32'd4);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("t6_reset");
        ref_leds = 16'd0;
        ref_ptr  = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("t6_no_rsp", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Both requesters valid for four commands: grants alternate from the reset pointer.
        c0 = 19'($urandom);
        c1 = 19'($urandom);
        req_cmd   = {c1, c0};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int n;
            int g;
            n = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 30) begin
                @(negedge clk);
                n++;
            end
            g = ref_ptr;
            chk("t2_grant", 32'(req_ready), 32'(1 << g));
            ref_ptr = (g + 1) % 2;
            @(posedge clk);
            #1;
            if (i == 3) req_valid = 2'b00;
            expect_rsp("t2_rr", g, (g == 0) ? c0 : c1, 0);
        end

        // Randomized commands from either requester, occasional response back-pressure.
        for (int it = 0; it < 24; it++) begin
            int r;
            int hold;
            r    = $urandom_range(0, 1);
            hold = $urandom_range(0, 2);
            c    = 19'($urandom);
            c.bypass_a = ($urandom_range(0, 3) == 0);
            c.bypass_b = ($urandom_range(0, 3) == 0);
            send(r, c);
            expect_rsp("rand", r, c, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
